datamem_lsu: RTL

Parametrised byte-addressable data memory for the single-cycle/pipelined CPU, sitting between the load/store path and the register file write-back. It replaces the flat word-only RAM with one-cycle registered reads, byte/half/word stores via byte lanes, sign/zero-extended loads and fault reporting for misaligned or out-of-range accesses. A post-reset clear sequencer zeroes the whole array before the first request is accepted.

---
 rtl/datamem_lsu_if.sv | 25 ++
 rtl/datamem_lsu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/datamem_lsu_if.sv
// Load/store request and response bundle between the CPU memory stage and datamem_lsu.
interface datamem_lsu_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [31:0]              req_wdata;
    logic                     rsp_valid;
    logic [31:0]              rsp_rdata;
    logic                     rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/datamem_lsu.sv
// Byte-addressable data memory with lane stores, extended loads, fault detection
// and a post-reset clear sweep that zeroes every word before requests are taken.
//
// state   | meaning
// S_CLEAR | sweeping r_idx over the array writing zeros; req_ready low
// S_RUN   | accepting one request per cycle; req_ready high
module datamem_lsu #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_WORDS     = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    datamem_lsu_if.slave  bus
);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [31:0]     r_mem [MEM_WORDS];

    logic            r_rsp_valid;
    logic [31:0]     r_rsp_rdata;
    logic            r_rsp_fault;

    logic            w_ready;
    logic            w_accept;
    logic            w_oob;
    logic            w_misalign;
    logic            w_fault;
    logic            w_store;
    logic [IW-1:0]   w_word_idx;
    logic [1:0]      w_off;
    logic [31:0]     w_rd_word;
    logic [7:0]      w_rd_byte;
    logic [15:0]     w_rd_half;
    logic [31:0]     w_load_data;
    logic [3:0]      w_be;
    logic [31:0]     w_mask;
    logic [31:0]     w_lane_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_CLEAR: if (r_idx == IW'(MEM_WORDS - 1)) w_state_nxt = S_RUN;
            S_RUN:   w_ready = 1'b1;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (r_state == S_CLEAR) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign w_accept   = bus.req_valid && w_ready;
    assign w_word_idx = bus.req_addr[IW+1:2];
    assign w_off      = bus.req_addr[1:0];
    // Any set bit above the array's byte range is out of bounds.
    assign w_oob      = (bus.req_addr >> (IW + 2)) != '0;

    always_comb begin
        w_misalign = 1'b0;
        case (bus.req_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_off[0];
            2'b10:   w_misalign = |w_off;
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_fault   = w_oob || w_misalign;
    assign w_store   = w_accept && bus.req_we && !w_fault;
    assign w_rd_word = r_mem[w_word_idx];
    assign w_rd_half = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        w_rd_byte = w_rd_word[7:0];
        case (w_off)
            2'd0:    w_rd_byte = w_rd_word[7:0];
            2'd1:    w_rd_byte = w_rd_word[15:8];
            2'd2:    w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
    end

    always_comb begin
        w_load_data = w_rd_word;
        w_be        = 4'b0000;
        w_lane_data = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                w_load_data = {{24{!bus.req_unsigned && w_rd_byte[7]}}, w_rd_byte};
                w_be        = 4'b0001 << w_off;
                w_lane_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_load_data = {{16{!bus.req_unsigned && w_rd_half[15]}}, w_rd_half};
                w_be        = w_off[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_load_data = w_rd_word;
                w_be        = 4'b1111;
                w_lane_data = bus.req_wdata;
            end
        endcase
    end

    assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

    // Array itself is not reset; the clear sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_idx] <= 32'h0;
        end else if (w_store) begin
            r_mem[w_word_idx] <= (w_rd_word & ~w_mask) | (w_lane_data & w_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_fault <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_fault <= w_accept && w_fault;
            r_rsp_rdata <= (w_accept && !bus.req_we && !w_fault) ? w_load_data : 32'h0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_fault = r_rsp_fault;
endmodule
